mmu_pager: RTL and testbench
============================

MMU_PAGER -- requirements
Module: mmu_pager

Interface
REQ-001 Parameter PPN_W, default 8, physical page number width; physical address width is PPN_W+12.
REQ-002 Parameter NPAGES, fixed 16, number of page-table entries; 4 KB pages over a 16-bit virtual space.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vaddr  in  16  CPU virtual address (cpu RAMaddr).
REQ-006 re / we  in  1 each  CPU read / write strobes.
REQ-007 be  in  1  CPU byte-enable; passed through unchanged.
REQ-008 super  in  1  1 = supervisor bank active; bypasses translation.
REQ-009 paging_en  in  1  control-register paging bit (CR bit 2).
REQ-010 pt_we  in  1  page-table write strobe.
REQ-011 pt_idx  in  4  page-table entry index.
REQ-012 pt_data  in  PPN_W+3  entry {valid, writable, user, ppn}.
REQ-013 fault_ack  in  1  CPU trap-deassert; clears the latched fault.
REQ-014 paddr  out  PPN_W+12  physical address.
REQ-015 mem_re / mem_we  out  1 each  gated strobes to RAM.
REQ-016 mem_be  out  1  equals be.
REQ-017 page_fault  out  1  registered fault indication to the CPU.
REQ-018 fault_vaddr  out  16  captured faulting virtual address.
REQ-019 fault_cause  out  2  01 invalid, 10 write-protect, 11 user-protect, 00 none.

Function
REQ-020 Translation is combinational in the access cycle: vpn = vaddr[15:12], offset = vaddr[11:0].
REQ-021 Translation is active when paging_en=1 and super=0; then paddr = {entry[vpn].ppn, offset}.
REQ-022 When translation is inactive, paddr = zero-extended vaddr and no fault is possible.
REQ-023 Cause priority, highest first: valid=0 -> 01; user=0 -> 11; we=1 with writable=0 -> 10.
REQ-024 A fault is detected when translation is active, (re|we)=1, any cause applies, and state=IDLE.
REQ-025 In the detecting cycle, mem_re and mem_we are forced 0 (no RAM side effect).
REQ-026 Otherwise mem_re=re and mem_we=we, except in state FAULT where both are forced 0 for user accesses and pass through for super=1.
REQ-027 The FSM has two states, IDLE and FAULT.
REQ-028 IDLE->FAULT on a detected fault; at that posedge, fault_vaddr<=vaddr, fault_cause<=cause, page_fault<=1.
REQ-029 FAULT->IDLE on a posedge with fault_ack=1; at that posedge page_fault<=0; fault_vaddr and fault_cause hold until the next fault.
REQ-030 In FAULT, further faults are not detected and the captured fields are not overwritten.
REQ-031 fault_ack in IDLE has no effect.
REQ-032 pt_we=1 writes pt_data into entry[pt_idx] at the posedge.
REQ-033 A translation in the same cycle as pt_we uses the pre-write entry.
REQ-034 pt_we is accepted in both states.

Reset
REQ-035 On reset: state=IDLE, page_fault=0, fault_vaddr=0, fault_cause=00, and all 16 entries=0 (invalid).
REQ-036 Reset overrides pt_we and fault detection in the same cycle.
REQ-037 Reset mid-FAULT returns to IDLE with no ack required.
REQ-038 During reset, paddr, mem_re and mem_we follow the combinational rules with the entries treated as already cleared.

Verification
REQ-039 Identity: paging_en=0, vaddr=0x1234, re=1 -> paddr=0x01234, mem_re=1, page_fault stays 0.
REQ-040 Translation: entry[3]={1,1,1,0x5A}, paging_en=1, super=0, vaddr=0x3ABC, we=1 -> paddr=0x5AABC, mem_we=1.
REQ-041 Invalid page: entry[7]=0, read vaddr=0x7000 -> mem_re=0 same cycle; next cycle page_fault=1, fault_vaddr=0x7000, fault_cause=01.
REQ-042 Write-protect: entry[2]={1,0,1,0x10}, we at 0x2004 -> fault_cause=10; a second fault before ack leaves fault_vaddr=0x2004; fault_ack=1 -> page_fault=0 next cycle.
REQ-043 Bypass and ordering: super=1 access at an invalid page gives no fault and an identity paddr; pt_we to entry 5 with a same-cycle read of page 5 uses the old entry, and the new entry is used the following cycle.
REQ-044 Reset in FAULT -> page_fault=0 and all entries invalid, so an access to page 3 faults with cause 01.

Source files
------------

// File: rtl/mmu_pager.sv
// Single-level pager: 16 x 4 KB pages over a 16-bit virtual space, combinational
// translation in the access cycle, and a latched page-fault report to the CPU.
module mmu_pager #(
  parameter int PPN_W  = 8,
  parameter int NPAGES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        i_vaddr,
  input  logic               i_re,
  input  logic               i_we,
  input  logic               i_be,
  input  logic               i_super,
  input  logic               i_paging_en,
  input  logic               i_pt_we,
  input  logic [3:0]         i_pt_idx,
  input  logic [PPN_W+2:0]   i_pt_data,
  input  logic               i_fault_ack,
  output logic [PPN_W+11:0]  o_paddr,
  output logic               o_mem_re,
  output logic               o_mem_we,
  output logic               o_mem_be,
  output logic               o_page_fault,
  output logic [15:0]        o_fault_vaddr,
  output logic [1:0]         o_fault_cause
);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_INVALID = 2'b01;
  localparam logic [1:0] CAUSE_WRPROT  = 2'b10;
  localparam logic [1:0] CAUSE_USER    = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_page_fault;
  logic [15:0]        r_fault_vaddr;
  logic [1:0]         r_fault_cause;
  logic [PPN_W+2:0]   r_pt [NPAGES];

  logic [3:0]         w_vpn;
  logic [PPN_W+2:0]   w_entry;
  logic               w_valid;
  logic               w_writable;
  logic               w_user;
  logic [PPN_W-1:0]   w_ppn;
  logic               w_xlate;
  logic [1:0]         w_cause;
  logic               w_detect;
  logic               w_block_user;

  // Entries must be clearable in one cycle, so the table lives in flops.
  generate
    for (genvar gi = 0; gi < NPAGES; gi++) begin : g_pt
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pt[gi] <= '0;
        end else if (i_pt_we && (i_pt_idx == 4'(gi))) begin
          r_pt[gi] <= i_pt_data;
        end
      end
    end
  endgenerate

  assign w_vpn      = i_vaddr[15:12];
  // While reset is held the table is already considered empty.
  assign w_entry    = reset ? '0 : r_pt[w_vpn];
  assign w_valid    = w_entry[PPN_W+2];
  assign w_writable = w_entry[PPN_W+1];
  assign w_user     = w_entry[PPN_W];
  assign w_ppn      = w_entry[PPN_W-1:0];
  assign w_xlate    = i_paging_en && !i_super;

  always_comb begin
    w_cause = CAUSE_NONE;
    if (!w_valid) begin
      w_cause = CAUSE_INVALID;
    end else if (!w_user) begin
      w_cause = CAUSE_USER;
    end else if (i_we && !w_writable) begin
      w_cause = CAUSE_WRPROT;
    end
  end

  assign w_detect     = w_xlate && (i_re || i_we) && (w_cause != CAUSE_NONE) &&
                        (r_state == ST_IDLE);
  assign w_block_user = (r_state == ST_FAULT) && !i_super;

  assign o_paddr  = w_xlate ? {w_ppn, i_vaddr[11:0]} : {{(PPN_W-4){1'b0}}, i_vaddr};
  assign o_mem_re = i_re && !w_detect && !w_block_user;
  assign o_mem_we = i_we && !w_detect && !w_block_user;
  assign o_mem_be = i_be;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_page_fault  <= 1'b0;
      r_fault_vaddr <= '0;
      r_fault_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_detect) begin
            r_state       <= ST_FAULT;
            r_page_fault  <= 1'b1;
            r_fault_vaddr <= i_vaddr;
            r_fault_cause <= w_cause;
          end
        end
        ST_FAULT: begin
          // Captured fields persist after the ack until the next fault.
          if (i_fault_ack) begin
            r_state      <= ST_IDLE;
            r_page_fault <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_page_fault  = r_page_fault;
  assign o_fault_vaddr = r_fault_vaddr;
  assign o_fault_cause = r_fault_cause;

endmodule

// File: tb/tb_mmu_pager.sv
// Bench for mmu_pager: directed scenarios plus random traffic, scored against a
// page-table reference model through an expectation queue.
module tb_mmu_pager;

  localparam int PPN_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       vaddr;
  logic              re, we, be, sup, pen, pt_we, fault_ack;
  logic [3:0]        pt_idx;
  logic [PPN_W+2:0]  pt_data;
  logic [PPN_W+11:0] paddr;
  logic              mem_re, mem_we, mem_be, page_fault;
  logic [15:0]       fault_vaddr;
  logic [1:0]        fault_cause;

  mmu_pager #(.PPN_W(PPN_W), .NPAGES(16)) dut (
    .clk(clk), .reset(reset), .i_vaddr(vaddr), .i_re(re), .i_we(we), .i_be(be),
    .i_super(sup), .i_paging_en(pen), .i_pt_we(pt_we), .i_pt_idx(pt_idx),
    .i_pt_data(pt_data), .i_fault_ack(fault_ack), .o_paddr(paddr),
    .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_page_fault(page_fault), .o_fault_vaddr(fault_vaddr), .o_fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] paddr;
    logic        mem_re, mem_we, mem_be, pf;
    logic [15:0] fv;
    logic [1:0]  fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: page table as plain fields, fault report as flags.
  bit          m_valid [16];
  bit          m_wr    [16];
  bit          m_user  [16];
  logic [7:0]  m_ppn   [16];
  bit          m_fault = 0;
  logic [15:0] m_fv = '0;
  logic [1:0]  m_fc = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int cause_of(bit rst, logic [15:0] va, bit w);
    int p = va[15:12];
    if (rst || !m_valid[p]) return 1;
    if (!m_user[p]) return 3;
    if (w && !m_wr[p]) return 2;
    return 0;
  endfunction

  function automatic bit detect_now();
    return pen && !sup && (re || we) && (cause_of(reset, vaddr, we) != 0) && !m_fault;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int p = vaddr[15:12];
    bit blocked = detect_now() || (m_fault && !sup);
    if (pen && !sup) e.paddr = (reset ? 20'h0 : {m_ppn[p], 12'h0}) + 20'(vaddr[11:0]);
    else             e.paddr = 20'(vaddr);
    e.mem_re = re && !blocked;
    e.mem_we = we && !blocked;
    e.mem_be = be;
    e.pf = m_fault;
    e.fv = m_fv;
    e.fc = m_fc;
    return e;
  endfunction

  task automatic drive(input bit rst, input logic [15:0] va, input bit r, input bit w,
                       input bit b, input bit s, input bit pe, input bit ptw,
                       input logic [3:0] idx, input logic [10:0] d, input bit ack);
    @(negedge clk);
    reset = rst; vaddr = va; re = r; we = w; be = b; sup = s; pen = pe;
    pt_we = ptw; pt_idx = idx; pt_data = d; fault_ack = ack;
    sb.push_back(predict());
  endtask

  task automatic finish_cycle();
    bit det;
    int c;
    det = detect_now();
    c = cause_of(reset, vaddr, we);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_wr[i] = 0; m_user[i] = 0; m_ppn[i] = '0;
      end
      m_fault = 0; m_fv = '0; m_fc = '0;
    end else begin
      if (det) begin
        m_fault = 1; m_fv = vaddr; m_fc = 2'(c);
      end else if (m_fault && fault_ack) begin
        m_fault = 0;
      end
      if (pt_we) begin
        m_valid[pt_idx] = pt_data[10]; m_wr[pt_idx] = pt_data[9];
        m_user[pt_idx] = pt_data[8];   m_ppn[pt_idx] = pt_data[7:0];
      end
    end
  endtask

  task automatic cyc(input bit rst, input logic [15:0] va, input bit r, input bit w,
                     input bit s, input bit pe, input bit ptw, input logic [3:0] idx,
                     input logic [10:0] d, input bit ack);
    drive(rst, va, r, w, 1'b0, s, pe, ptw, idx, d, ack);
    finish_cycle();
  endtask

  // Monitor: every issued access produces one expectation, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("paddr",       32'(paddr),       32'(e.paddr));
        chk("mem_re",      32'(mem_re),      32'(e.mem_re));
        chk("mem_we",      32'(mem_we),      32'(e.mem_we));
        chk("mem_be",      32'(mem_be),      32'(e.mem_be));
        chk("page_fault",  32'(page_fault),  32'(e.pf));
        chk("fault_vaddr", 32'(fault_vaddr), 32'(e.fv));
        chk("fault_cause", 32'(fault_cause), 32'(e.fc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_wr[i] = 0; m_user[i] = 0; m_ppn[i] = '0;
    end
    reset = 1; vaddr = '0; re = 0; we = 0; be = 0; sup = 0; pen = 0;
    pt_we = 0; pt_idx = '0; pt_data = '0; fault_ack = 0;
    repeat (2) @(posedge clk);

    // Reset state, including a pt_we that reset must override.
    drive(1, 16'h0, 0, 0, 0, 0, 0, 1, 4'd1, 11'h7FF, 0);
    #4; chk("rst_pf", 32'(page_fault), 0); chk("rst_fc", 32'(fault_cause), 0);
    chk("rst_fv", 32'(fault_vaddr), 0);
    finish_cycle();

    // Identity mapping with paging off.
    drive(0, 16'h1234, 1, 0, 1, 0, 0, 0, 4'd0, 11'h0, 0);
    #4; chk("id_paddr", 32'(paddr), 32'h01234); chk("id_mem_re", 32'(mem_re), 1);
    finish_cycle();
    drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 4'd0, 11'h0, 0);
    #4; chk("id_pf", 32'(page_fault), 0);
    finish_cycle();

    // Translation through entry 3 = {1,1,1,0x5A}.
    cyc(0, 16'h0, 0, 0, 0, 0, 1, 4'd3, 11'h75A, 0);
    drive(0, 16'h3ABC, 0, 1, 0, 0, 1, 0, 4'd0, 11'h0, 0);
    #4; chk("xl_paddr", 32'(paddr), 32'h5AABC); chk("xl_mem_we", 32'(mem_we), 1);
    finish_cycle();

    // Invalid page read.
    drive(0, 16'h7000, 1, 0, 0, 0, 1, 0, 4'd0, 11'h0, 0);
    #4; chk("inv_mem_re", 32'(mem_re), 0);
    finish_cycle();
    drive(0, 16'h0, 0, 0, 0, 0, 1, 0, 4'd0, 11'h0, 1);
    #4; chk("inv_pf", 32'(page_fault), 1); chk("inv_fv", 32'(fault_vaddr), 32'h7000);
    chk("inv_fc", 32'(fault_cause), 1);
    finish_cycle();

    // Write-protect, then a second fault before the ack.
    cyc(0, 16'h0, 0, 0, 0, 0, 1, 4'd2, 11'h510, 0);
    cyc(0, 16'h2004, 0, 1, 0, 1, 0, 4'd0, 11'h0, 0);
    drive(0, 16'h7000, 1, 0, 0, 0, 1, 0, 4'd0, 11'h0, 0);
    #4; chk("wp_pf", 32'(page_fault), 1); chk("wp_fc", 32'(fault_cause), 2);
    chk("wp_blocked_re", 32'(mem_re), 0);
    finish_cycle();
    drive(0, 16'h0, 0, 0, 0, 0, 1, 0, 4'd0, 11'h0, 1);
    #4; chk("wp_hold_fv", 32'(fault_vaddr), 32'h2004); chk("wp_hold_fc", 32'(fault_cause), 2);
    finish_cycle();
    drive(0, 16'h0, 0, 0, 0, 0, 1, 0, 4'd0, 11'h0, 0);
    #4; chk("ack_pf", 32'(page_fault), 0); chk("ack_fv", 32'(fault_vaddr), 32'h2004);
    finish_cycle();

    // Supervisor bypass and page-table write ordering.
    drive(0, 16'h7000, 1, 0, 0, 1, 1, 0, 4'd0, 11'h0, 0);
    #4; chk("sup_paddr", 32'(paddr), 32'h07000); chk("sup_mem_re", 32'(mem_re), 1);
    finish_cycle();
    cyc(0, 16'h0, 0, 0, 0, 1, 1, 4'd5, 11'h733, 0);
    drive(0, 16'h5123, 1, 0, 0, 0, 1, 1, 4'd5, 11'h7AB, 0);
    #4; chk("ord_old", 32'(paddr), 32'h33123); chk("ord_pf_clear", 32'(page_fault), 0);
    finish_cycle();
    drive(0, 16'h5123, 1, 0, 0, 0, 1, 0, 4'd0, 11'h0, 0);
    #4; chk("ord_new", 32'(paddr), 32'hAB123);
    finish_cycle();

    // Reset in FAULT clears the report and the table.
    cyc(0, 16'h7000, 1, 0, 0, 1, 0, 4'd0, 11'h0, 0);
    cyc(1, 16'h0, 0, 0, 0, 0, 0, 4'd0, 11'h0, 0);
    drive(0, 16'h3000, 1, 0, 0, 0, 1, 0, 4'd0, 11'h0, 0);
    #4; chk("rf_pf", 32'(page_fault), 0); chk("rf_mem_re", 32'(mem_re), 0);
    finish_cycle();
    drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 4'd0, 11'h0, 1);
    #4; chk("rf_pf2", 32'(page_fault), 1); chk("rf_fc", 32'(fault_cause), 1);
    finish_cycle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 79) == 0, 16'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, 4'($urandom),
            {($urandom_range(0, 4) != 0), 10'($urandom)}, $urandom_range(0, 3) == 0);
      finish_cycle();
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
